// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, widths and byte order.
package instruction_loader_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    // Big-endian image: the high byte of a word lands on the even address.
    localparam bit HI_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WR_HI,
        ST_WR_LO,
        ST_DONE
    } state_t;

    // Byte of a word destined for the even (odd_addr=0) or odd (odd_addr=1) address.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                    input logic              odd_addr);
        if (odd_addr == HI_FIRST) begin
            return word[BYTE_W-1:0];
        end
        return word[WORD_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/instruction_loader.sv
// Accepts 16-bit instruction words over a valid/ready handshake and writes each one
// into a byte-wide instruction memory as two consecutive byte writes.
module instruction_loader
    import instruction_loader_pkg::state_t,
           instruction_loader_pkg::ST_IDLE,
           instruction_loader_pkg::ST_ACCEPT,
           instruction_loader_pkg::ST_WR_HI,
           instruction_loader_pkg::ST_WR_LO,
           instruction_loader_pkg::ST_DONE,
           instruction_loader_pkg::BYTE_W,
           instruction_loader_pkg::CNT_W,
           instruction_loader_pkg::word_byte;
#(
    parameter int ADDR_W = instruction_loader_pkg::ADDR_W,
    parameter int WORD_W = instruction_loader_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_count
);

    // Start address of the topmost byte pair; the pointer never moves past it.
    localparam logic [ADDR_W-1:0] LAST_PAIR = {{(ADDR_W-1){1'b1}}, 1'b0};

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [WORD_W-1:0] r_word;
    logic              r_last;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_word_count;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [BYTE_W-1:0] r_mem_wdata;
    logic              w_start_ok;
    logic              w_handshake;
    logic              w_at_end;

    assign w_at_end = (r_ptr == LAST_PAIR);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_handshake  = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_handshake  = 1'b1;
                    w_state_next = ST_WR_HI;
                end
            end
            ST_WR_HI: w_state_next = ST_WR_LO;
            ST_WR_LO: w_state_next = (r_last || w_at_end) ? ST_DONE : ST_ACCEPT;
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write strobe/address/data are registered one state ahead so they line up with
    // WR_HI/WR_LO and simply hold between writes. The memory itself is external and
    // is deliberately left untouched by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr        <= '0;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok) begin
                r_ptr        <= {base_addr[ADDR_W-1:1], 1'b0};
                r_word_count <= '0;
                r_overflow   <= 1'b0;
            end
            if (w_handshake) begin
                r_word      <= in_data;
                r_last      <= in_last;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= word_byte(in_data, 1'b0);
            end
            if (r_state == ST_WR_HI) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= {r_ptr[ADDR_W-1:1], 1'b1};
                r_mem_wdata <= word_byte(r_word, 1'b1);
            end
            if (r_state == ST_WR_LO) begin
                r_word_count <= r_word_count + CNT_W'(1);
                if (!w_at_end) begin
                    r_ptr <= r_ptr + ADDR_W'(2);
                end else if (!r_last) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench: a timeline model of expected outputs checked every cycle,
// directed sessions pinned by literal write logs, and randomized sessions.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  word_count;

    instruction_loader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a queue of scheduled future cycles ----------------
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       dn;
        logic       bump;
        logic       ovf;
    } rec_t;

    function automatic rec_t mk(input logic we, input logic [7:0] a, input logic [7:0] d,
                                input logic dn, input logic bump, input logic ovf);
        rec_t r;
        r.we = we; r.addr = a; r.data = d; r.dn = dn; r.bump = bump; r.ovf = ovf;
        return r;
    endfunction

    rec_t       m_q[$];
    rec_t       m_r;
    bit         m_session;
    bit         m_end;
    logic [7:0] m_ptr, m_cnt, m_last_addr, m_last_data;
    logic       m_ovf;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_session   = 1'b0;
            m_ptr       = 8'h00;
            m_cnt       = 8'h00;
            m_ovf       = 1'b0;
            m_last_addr = 8'h00;
            m_last_data = 8'h00;
        end else if (m_q.size() > 0) begin
            m_r = m_q.pop_front();
            if (m_r.we) begin
                m_last_addr = m_r.addr;
                m_last_data = m_r.data;
            end
            if (m_r.bump) begin
                m_cnt = m_cnt + 8'd1;
                if (m_r.ovf) m_ovf = 1'b1;
            end
        end else if (m_session) begin
            if (in_valid) begin
                m_end = (m_ptr == 8'hFE);
                m_q.push_back(mk(1'b1, m_ptr, in_data[15:8], 1'b0, 1'b0, 1'b0));
                m_q.push_back(mk(1'b1, m_ptr + 8'd1, in_data[7:0], 1'b0, 1'b1, m_end && !in_last));
                if (in_last || m_end) begin
                    m_q.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
                    m_session = 1'b0;
                end else begin
                    m_ptr = m_ptr + 8'd2;
                end
            end
        end else if (start) begin
            m_session = 1'b1;
            m_ptr     = base_addr & 8'hFE;
            m_cnt     = 8'h00;
            m_ovf     = 1'b0;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    logic       e_rdy, e_busy, e_we, e_done;
    logic [7:0] e_addr, e_data;

    always @(negedge clk) begin
        if (m_q.size() > 0) begin
            e_rdy  = 1'b0;
            e_busy = 1'b1;
            e_we   = m_q[0].we;
            e_done = m_q[0].dn;
            e_addr = m_q[0].we ? m_q[0].addr : m_last_addr;
            e_data = m_q[0].we ? m_q[0].data : m_last_data;
        end else begin
            e_rdy  = m_session;
            e_busy = m_session;
            e_we   = 1'b0;
            e_done = 1'b0;
            e_addr = m_last_addr;
            e_data = m_last_data;
        end
        check("cyc in_ready", in_ready, e_rdy);
        check("cyc busy", busy, e_busy);
        check("cyc mem_we", mem_we, e_we);
        check("cyc done", done, e_done);
        check("cyc mem_addr", mem_addr, e_addr);
        check("cyc mem_wdata", mem_wdata, e_data);
        check("cyc word_count", word_count, m_cnt);
        check("cyc overflow", overflow, m_ovf);
    end

    // ---------------- write log and done counter ----------------
    logic [7:0] log_a[$];
    logic [7:0] log_d[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
        end
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [7:0] b);
        start = 1'b1;
        base_addr = b;
        step();
        start = 1'b0;
        base_addr = 8'($urandom);
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, input int gap,
                             input int budget, input bit noisy, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            in_data   = 16'($urandom);
            in_last   = 1'($urandom);
            start     = noisy && ($urandom % 3 == 0);
            base_addr = 8'($urandom);
            step();
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (busy === 1'b0);
            step();
        end
        check(name, ok, 1);
    endtask

    task automatic check_wr(input string name, input int idx, input logic [7:0] a, input logic [7:0] d);
        check({name, " present"}, 32'(idx < log_a.size()), 1);
        if (idx < log_a.size()) begin
            check({name, " addr"}, log_a[idx], a);
            check({name, " data"}, log_d[idx], d);
        end
    endtask

    localparam logic [15:0] T1_W [4] = '{16'h3112, 16'h3413, 16'h0140, 16'h0241};
    localparam logic [7:0]  T1_D [8] = '{8'h31, 8'h12, 8'h34, 8'h13, 8'h01, 8'h40, 8'h02, 8'h41};

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, d0;
        bit ok;
        logic [7:0] b;
        int n, room, acc;

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 0);
        check("rst busy", busy, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst word_count", word_count, 0);
        check("rst overflow", overflow, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        step();

        // Four words from base 0 with last on the fourth.
        lb = log_a.size(); d0 = done_cnt;
        start_session(8'h00);
        for (int k = 0; k < 4; k++) begin
            send_word(T1_W[k], k == 3, 0, 50, 0, ok);
            check("t1 handshake", ok, 1);
        end
        wait_idle("t1 idle");
        check("t1 write count", log_a.size() - lb, 8);
        for (int k = 0; k < 8; k++) check_wr("t1 wr", lb + k, 8'(k), T1_D[k]);
        check("t1 done pulses", done_cnt - d0, 1);
        check("t1 word_count", word_count, 4);
        check("t1 overflow", overflow, 0);

        // Odd base address is forced even.
        lb = log_a.size();
        start_session(8'h05);
        send_word(16'hABCD, 1'b1, 2, 50, 0, ok);
        check("t2 handshake", ok, 1);
        wait_idle("t2 idle");
        check("t2 write count", log_a.size() - lb, 2);
        check_wr("t2 hi", lb, 8'h04, 8'hAB);
        check_wr("t2 lo", lb + 1, 8'h05, 8'hCD);
        check("t2 word_count", word_count, 1);

        // Running off the top of memory.
        lb = log_a.size(); d0 = done_cnt;
        start_session(8'hFC);
        send_word(16'h1122, 1'b0, 0, 50, 0, ok);
        check("t3 handshake 1", ok, 1);
        send_word(16'h3344, 1'b0, 0, 50, 0, ok);
        check("t3 handshake 2", ok, 1);
        send_word(16'h5566, 1'b0, 0, 8, 0, ok);
        check("t3 third word refused", ok, 0);
        wait_idle("t3 idle");
        check("t3 write count", log_a.size() - lb, 4);
        check_wr("t3 wr0", lb,     8'hFC, 8'h11);
        check_wr("t3 wr1", lb + 1, 8'hFD, 8'h22);
        check_wr("t3 wr2", lb + 2, 8'hFE, 8'h33);
        check_wr("t3 wr3", lb + 3, 8'hFF, 8'h44);
        check("t3 done pulses", done_cnt - d0, 1);
        check("t3 word_count", word_count, 2);
        repeat (3) step();
        check("t3 overflow sticky", overflow, 1);

        // Start pulses while busy are ignored.
        lb = log_a.size();
        start_session(8'h40);
        check("t5 overflow cleared", overflow, 0);
        send_word(16'hBEEF, 1'b0, 0, 50, 0, ok);
        check("t5 handshake 1", ok, 1);
        start = 1'b1; base_addr = 8'h80;
        step();
        start = 1'b0;
        send_word(16'hCAFE, 1'b1, 4, 50, 1, ok);
        check("t5 handshake 2", ok, 1);
        wait_idle("t5 idle");
        check("t5 write count", log_a.size() - lb, 4);
        check_wr("t5 wr0", lb,     8'h40, 8'hBE);
        check_wr("t5 wr1", lb + 1, 8'h41, 8'hEF);
        check_wr("t5 wr2", lb + 2, 8'h42, 8'hCA);
        check_wr("t5 wr3", lb + 3, 8'h43, 8'hFE);
        check("t5 word_count", word_count, 2);

        // Reset asserted during the low-byte write of the second word.
        lb = log_a.size();
        start_session(8'h10);
        send_word(16'h0A0B, 1'b0, 0, 50, 0, ok);
        check("t4 handshake 1", ok, 1);
        send_word(16'h0C0D, 1'b0, 1, 50, 0, ok);
        check("t4 handshake 2", ok, 1);
        step();
        #2 reset = 1'b0;
        #1;
        check("t4 rst mem_we", mem_we, 0);
        check("t4 rst busy", busy, 0);
        check("t4 rst in_ready", in_ready, 0);
        check("t4 rst word_count", word_count, 0);
        check("t4 rst mem_addr", mem_addr, 0);
        check("t4 rst mem_wdata", mem_wdata, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        step();
        check("t4 partial write count", log_a.size() - lb, 3);
        check_wr("t4 wr2", lb + 2, 8'h12, 8'h0C);
        lb = log_a.size();
        start_session(8'h20);
        send_word(16'h1357, 1'b0, 0, 50, 0, ok);
        check("t4 restart handshake 1", ok, 1);
        send_word(16'h2468, 1'b1, 0, 50, 0, ok);
        check("t4 restart handshake 2", ok, 1);
        wait_idle("t4 restart idle");
        check_wr("t4 re wr0", lb,     8'h20, 8'h13);
        check_wr("t4 re wr3", lb + 3, 8'h23, 8'h68);
        check("t4 restart word_count", word_count, 2);

        // Randomized sessions with gaps, noisy start pulses and occasional end-of-memory.
        for (int s = 0; s < 60; s++) begin
            b    = ($urandom % 3 == 0) ? 8'(8'hF0 + $urandom % 16) : 8'($urandom);
            n    = 1 + int'($urandom % 6);
            room = (256 - int'(b & 8'hFE)) / 2;
            acc  = (n < room) ? n : room;
            start_session(b);
            for (int k = 0; k < acc; k++) begin
                send_word(16'($urandom), k == n - 1, int'($urandom % 4), 50, 1, ok);
                check("rand handshake", ok, 1);
            end
            if (n > room) begin
                send_word(16'($urandom), 1'b1, 0, 6, 0, ok);
                check("rand refused past end", ok, 0);
            end
            wait_idle("rand idle");
            check("rand word_count", word_count, 32'(acc));
            check("rand overflow", overflow, (n > room) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, byte-address width of the target instruction memory (256 bytes).
REQ-002 Parameter: WORD_W, default 16, instruction width, fixed at two bytes per word.
REQ-003 clk  input  1  single system clock, all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session at base_addr.
REQ-006 base_addr  input  8  first byte address of the session; bit 0 is ignored (forced even).
REQ-007 in_valid  input  1  source presents an instruction word.
REQ-008 in_data  input  16  instruction word; [15:8] is the high byte, [7:0] is the low byte.
REQ-009 in_last  input  1  qualifies in_data as the final word of the session.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_we  output  1  byte write strobe to the instruction memory.
REQ-012 mem_addr  output  8  byte write address.
REQ-013 mem_wdata  output  8  byte write data.
REQ-014 busy  output  1  high from the cycle after start until DONE exits.
REQ-015 done  output  1  one-cycle pulse when the session ends.
REQ-016 overflow  output  1  sticky flag: the session ended because memory ran out; cleared by the next accepted start.
REQ-017 word_count  output  8  number of words written in the current or last session.

Function
REQ-018 FSM states: IDLE, ACCEPT, WR_HI, WR_LO, DONE.
REQ-019 IDLE: on start, load ptr={base_addr[7:1],0}, clear word_count and overflow, then enter ACCEPT; start is ignored in all other states.
REQ-020 ACCEPT: in_ready=1; handshake on in_valid&in_ready captures in_data and in_last into holding registers, then enters WR_HI.
REQ-021 WR_HI: mem_we=1, mem_addr=ptr, mem_wdata=word[15:8]; next state is WR_LO.
REQ-022 WR_LO: mem_we=1, mem_addr=ptr+1, mem_wdata=word[7:0]; ptr+=2 and word_count+=1 at the cycle end.
REQ-023 WR_LO exit: go to DONE if last was captured or ptr==254 (final pair written); otherwise return to ACCEPT.
REQ-024 Overflow: set only when WR_LO exits at ptr==254 with last not captured; no further word is accepted and ptr does not wrap.
REQ-025 DONE: done=1 for exactly one cycle, then return to IDLE; word_count and overflow hold their values.
REQ-026 Byte order is big-endian: the high byte goes to the even address and the low byte to the odd address, so a word written at A reads back as {mem[A],mem[A+1]}.
REQ-027 Throughput: at most one word per 3 cycles; latency from the handshake to the high-byte write is 1 cycle.
REQ-028 Outside WR_HI and WR_LO: mem_we=0, and mem_addr/mem_wdata hold their last values.
REQ-029 Dropping in_valid in ACCEPT stalls the loader indefinitely with no timeout; in_data is sampled only on the handshake.

Reset
REQ-030 Reset asserted (reset=0) at any time forces IDLE immediately, including mid-write.
REQ-031 Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, word_count=0, ptr=0, holding registers=0.
REQ-032 Memory contents are not touched by reset; a partially loaded word remains partially written.

Structure
REQ-033 The shared package holds the FSM state enum, ADDR_W, WORD_W, and the byte-order constants (HI_FIRST).
REQ-034 The block is one module with no sub-modules; the address and word counters are inline registers.

Verification
REQ-035 Base 0x00, four words 0x3112, 0x3413, 0x0140, 0x0241, last on the fourth -> writes in order 0x31@0, 0x12@1, 0x34@2, 0x13@3, 0x01@4, 0x40@5, 0x02@6, 0x41@7; done pulses once; word_count=4; overflow=0.
REQ-036 Base 0x05, one word 0xABCD with last -> 0xAB@4 and 0xCD@5 (bit 0 ignored); word_count=1.
REQ-037 Base 0xFC, three words without last -> writes at 0xFC..0xFF, done after the second word, overflow=1, word_count=2, third word never accepted (in_ready stays 0).
REQ-038 in_valid toggled 0/1 with a random gap between words -> no duplicate or missed writes, and each write lands 1 cycle after its handshake.
REQ-039 Reset pulsed low during WR_LO of the second word -> next cycle all outputs are at reset values, state is IDLE, and a new start loads correctly.
REQ-040 start pulsed while busy -> ignored; ptr and word_count are unaffected.
